mem_access_unit: RTL

//   MEM-stage load/store engine: the data-side counterpart of immediate extension.

---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine between the pipeline and a
// variable-latency data memory using a req/ack handshake.
//   Stores: narrow and lane-replicate register data, generate byte enables.
//   Loads : pick the addressed byte/halfword from the returned word and
//           sign- or zero-extend it.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake from the MEM stage
//   req_op                0 LW,1 LH,2 LHU,3 LB,4 LBU,5 SW,6 SH,7 SB
//   req_addr, req_wdata   byte address and store data
//   rsp_valid/err/rdata   one-cycle completion pulse with status and load data
//   stall                 hold the pipeline while the access is outstanding
//   mem_req/we/be/addr/wdata, mem_ack/rdata  data-memory side
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             we_q;
  logic [31:0]      rdata_q;

  // Decode of the incoming request (used only at accept time)
  logic        mis_n;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic        we_n;

  always_comb begin
    mis_n   = 1'b0;
    be_n    = 4'b0000;
    wdata_n = '0;
    we_n    = (req_op >= 3'd5);
    case (req_op)
      3'd0, 3'd5: begin
        mis_n   = (req_addr[1:0] != 2'b00);
        be_n    = 4'b1111;
        wdata_n = req_wdata;
      end
      3'd1, 3'd2, 3'd6: begin
        mis_n   = req_addr[0];
        be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{req_wdata[15:0]}};
      end
      default: begin
        mis_n   = 1'b0;
        be_n    = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
    endcase
    if (!we_n) wdata_n = '0;
  end

  // Load extraction from the returned word, using the latched op/address
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      3'd0:    ld_data = mem_rdata;
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_data = {16'h0000, ld_half};
      3'd3:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'h000000, ld_byte};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= wdata_n;
            be_q    <= be_n;
            we_q    <= we_n;
            rdata_q <= '0;
            state   <= mis_n ? S_ERR : S_BUS;
          end
        end
        S_BUS: begin
          // An ack arriving on the final allowed cycle still completes normally
          if (mem_ack) begin
            rdata_q <= ld_data;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic in_bus;
  assign in_bus = (state == S_BUS);

  assign req_ready = (state == S_IDLE);
  assign stall     = in_bus | (req_valid & (state == S_IDLE));
  assign rsp_valid = (state == S_RESP) | (state == S_ERR);
  assign rsp_err   = (state == S_ERR);
  assign rsp_rdata = (state == S_RESP) ? rdata_q : '0;

  assign mem_req   = in_bus;
  assign mem_we    = in_bus & we_q;
  assign mem_be    = in_bus ? be_q : 4'b0000;
  assign mem_addr  = in_bus ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = in_bus ? wdata_q : '0;

endmodule
